// File: rtl/if_id_decode_if.sv
// -----------------------------------------------------------------------------
// if_id_decode_if
// Bundles the two valid/ready channels of the IF/ID stage:
//   fetch side   : in_valid, in_ready, instr_in, pc_in
//   execute side : out_valid, out_ready, pc_out and the decoded instruction
//                  fields (opcode, rs, rt, rd, shamt, funct, imm16, is_rtype)
// Modports:
//   slave  - the IF/ID stage itself (accepts fetch words, presents fields)
//   master - the surrounding pipeline (fetch drives, execute consumes)
// -----------------------------------------------------------------------------
interface if_id_decode_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] pc_out;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic            is_rtype;

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, pc_out, opcode, rs, rt, rd, shamt, funct,
               imm16, is_rtype
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, opcode, rs, rt, rd, shamt, funct,
               imm16, is_rtype
    );
endinterface

// File: rtl/if_id_decode.sv
// -----------------------------------------------------------------------------
// if_id_decode
// IF/ID pipeline stage. Buffers fetched instructions in a 2-entry skid buffer
// (head + skid) and presents the head entry split into its MIPS-style fields.
// in_ready and out_valid are decoded from the state register only, so there is
// no combinational path from out_ready to in_ready.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous discard of all buffered instructions
//   bus       if_id_decode_if.slave (fetch and execute handshakes, fields)
//   perf_cnt  out  32-bit count of pops (only with DECODE_PERF_CNT_EN)
//
// Parameters:
//   PC_W       width of the PC carried with each instruction
//   NOP_INSTR  word loaded into both entries on reset and flush
//
// Configuration macro:
//   DECODE_PERF_CNT_EN  adds the perf_cnt port and its counter
// -----------------------------------------------------------------------------
module if_id_decode #(
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    if_id_decode_if.slave bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]   perf_cnt
`endif
);

    // State encodes the number of buffered entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     head_q, skid_q;
    logic [PC_W-1:0] head_pc_q, skid_pc_q;

    logic push, pop;
    logic load_head_in, load_head_skid, load_skid;

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        load_head_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        // Head leaves and the new word replaces it in place.
                        load_head_in = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        load_head_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // NOTE: the data entries are reset too, because the field outputs are
    // visible (as the NOP decode) even while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= NOP_INSTR;
            skid_q    <= NOP_INSTR;
            head_pc_q <= '0;
            skid_pc_q <= '0;
        end else if (flush) begin
            head_q    <= NOP_INSTR;
            skid_q    <= NOP_INSTR;
            head_pc_q <= '0;
            skid_pc_q <= '0;
        end else begin
            if (load_head_in) begin
                head_q    <= bus.instr_in;
                head_pc_q <= bus.pc_in;
            end else if (load_head_skid) begin
                head_q    <= skid_q;
                head_pc_q <= skid_pc_q;
            end
            if (load_skid) begin
                skid_q    <= bus.instr_in;
                skid_pc_q <= bus.pc_in;
            end
        end
    end

    // Field outputs are plain slices of the head entry.
    assign bus.pc_out   = head_pc_q;
    assign bus.opcode   = head_q[31:26];
    assign bus.rs       = head_q[25:21];
    assign bus.rt       = head_q[20:16];
    assign bus.rd       = head_q[15:11];
    assign bus.shamt    = head_q[10:6];
    assign bus.funct    = head_q[5:0];
    assign bus.imm16    = head_q[15:0];
    assign bus.is_rtype = (head_q[31:26] == 6'b0);

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    // Pops in a flush cycle are not counted; only rst_n clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            perf_cnt_q <= '0;
        else if (pop && !flush) perf_cnt_q <= perf_cnt_q + 32'd1;
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
